reorder_buffer: RTL and testbench

//  Circular reorder buffer for the Tomasulo core. Sits between decode/dispatch and the architectural regfile.

---
 rtl/ooo_itfs_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 115 +++++++++++
 tb/tb_reorder_buffer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ooo_itfs_pkg.sv
// Shared Tomasulo types: reorder-buffer sizing and the entry record used by the
// ROB, the regfile tag logic and the reservation stations.
package ooo_itfs;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, captures CDB results,
// retires in program order into the regfile and flushes on a mispredict.
module reorder_buffer
  import ooo_itfs::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  localparam int unsigned TW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [4:0]    alloc_rd,
  output logic          alloc_ready,
  output logic [TW-1:0] alloc_tag,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [31:0]   cdb_val,
  input  logic          cdb_mispredict,
  input  logic [31:0]   cdb_target,
  input  logic [TW-1:0] rd_tag1,
  input  logic [TW-1:0] rd_tag2,
  output logic          rd_rdy1,
  output logic          rd_rdy2,
  output logic [31:0]   rd_val1,
  output logic [31:0]   rd_val2,
  output logic          commit_load,
  output logic [4:0]    commit_rd,
  output logic [31:0]   commit_val,
  output logic [TW-1:0] commit_tag,
  output logic          flush,
  output logic [31:0]   flush_pc
);

  localparam int unsigned CW = TW + 1;

  rob_entry_t    entries [DEPTH];
  logic [TW-1:0] head;
  logic [TW-1:0] tail;
  logic [CW-1:0] count;

  rob_entry_t head_entry;
  logic       retire;
  logic       do_alloc;
  logic       do_cdb;

  // Retire/flush/allocate decisions, all from registered state plus this cycle's requests.
  always_comb begin
    head_entry  = entries[head];
    retire      = head_entry.valid && head_entry.done;
    flush       = retire && head_entry.mispredict;
    flush_pc    = flush ? head_entry.target : '0;
    commit_load = retire && (head_entry.rd != 5'd0);
    commit_rd   = retire ? head_entry.rd : '0;
    commit_val  = retire ? head_entry.val : '0;
    commit_tag  = head;
    // A retire in this same cycle does not free a slot until the next cycle.
    alloc_ready = (count < CW'(DEPTH)) && !flush;
    alloc_tag   = tail;
    do_alloc    = alloc_valid && alloc_ready;
    do_cdb      = cdb_valid && entries[cdb_tag].valid && !flush;
  end

  // Operand lookup for the decoder; value is forced to zero until the entry is done.
  always_comb begin
    rd_rdy1 = entries[rd_tag1].valid && entries[rd_tag1].done;
    rd_rdy2 = entries[rd_tag2].valid && entries[rd_tag2].done;
    rd_val1 = rd_rdy1 ? entries[rd_tag1].val : '0;
    rd_val2 = rd_rdy2 ? entries[rd_tag2].val : '0;
  end

  // Entry array, pointers and occupancy; a flush wipes everything and drops
  // any allocate or CDB write presented in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_cdb) begin
        entries[cdb_tag].done       <= 1'b1;
        entries[cdb_tag].val        <= cdb_val;
        entries[cdb_tag].mispredict <= cdb_mispredict;
        entries[cdb_tag].target     <= cdb_target;
      end
      if (retire) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
        head                <= head + TW'(1);
      end
      // Tail never aliases a retiring head: that would need a full buffer, which blocks alloc.
      if (do_alloc) begin
        entries[tail].valid      <= 1'b1;
        entries[tail].done       <= 1'b0;
        entries[tail].rd         <= alloc_rd;
        entries[tail].mispredict <= 1'b0;
        tail                     <= tail + TW'(1);
      end
      unique case ({do_alloc, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push expected commits in
// program order, CDB writes record expected values, commits pop and compare.
module tb_reorder_buffer;
  import ooo_itfs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [2:0]  rd_tag1;
  logic [2:0]  rd_tag2;
  logic        rd_rdy1;
  logic        rd_rdy2;
  logic [31:0] rd_val1;
  logic [31:0] rd_val2;
  logic        commit_load;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [2:0]  commit_tag;
  logic        flush;
  logic [31:0] flush_pc;

  reorder_buffer #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_rd       (alloc_rd),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_val        (cdb_val),
    .cdb_mispredict (cdb_mispredict),
    .cdb_target     (cdb_target),
    .rd_tag1        (rd_tag1),
    .rd_tag2        (rd_tag2),
    .rd_rdy1        (rd_rdy1),
    .rd_rdy2        (rd_rdy2),
    .rd_val1        (rd_val1),
    .rd_val2        (rd_val2),
    .commit_load    (commit_load),
    .commit_rd      (commit_rd),
    .commit_val     (commit_val),
    .commit_tag     (commit_tag),
    .flush          (flush),
    .flush_pc       (flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tag;
    logic [4:0] rd;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_val [8];
  logic [2:0]  exp_tail;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_drive(input logic [2:0] tag, input logic [31:0] val,
                           input logic mis, input logic [31:0] tgt);
    cdb_valid      = 1'b1;
    cdb_tag        = tag;
    cdb_val        = val;
    cdb_mispredict = mis;
    cdb_target     = tgt;
    model_val[tag] = val;
  endtask

  task automatic cdb_off();
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    exp_t e;
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    @(negedge clk);
    check_eq("alloc_ready", 32'(alloc_ready), 1);
    check_eq("alloc_tag", 32'(alloc_tag), 32'(exp_tail));
    e.tag = exp_tail;
    e.rd  = rd;
    sb.push_back(e);
    exp_tail++;
    tick();
    alloc_valid = 1'b0;
  endtask

  // Caller is positioned at a negedge in a cycle where the head must retire.
  task automatic commit_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({name, "_sb_size"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_eq({name, "_load"}, 32'(commit_load), 32'(e.rd != 5'd0));
      check_eq({name, "_rd"}, 32'(commit_rd), 32'(e.rd));
      check_eq({name, "_val"}, commit_val, model_val[e.tag]);
      check_eq({name, "_tag"}, 32'(commit_tag), 32'(e.tag));
    end
  endtask

  task automatic commit_none(input string name);
    check_eq({name, "_load"}, 32'(commit_load), 0);
    check_eq({name, "_flush"}, 32'(flush), 0);
  endtask

  // Assert reset mid-cycle and check the outputs settle without waiting for a clock.
  task automatic reset_mid(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq({name, "_ready"}, 32'(alloc_ready), 1);
    check_eq({name, "_tag"}, 32'(alloc_tag), 0);
    check_eq({name, "_load"}, 32'(commit_load), 0);
    check_eq({name, "_flush"}, 32'(flush), 0);
    check_eq({name, "_rdy1"}, 32'(rd_rdy1), 0);
    check_eq({name, "_cval"}, commit_val, 0);
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    exp_tail = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    alloc_valid    = 1'b0;
    alloc_rd       = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_val        = '0;
    cdb_mispredict = 1'b0;
    cdb_target     = '0;
    rd_tag1        = '0;
    rd_tag2        = '0;
    exp_tail       = '0;
    for (int i = 0; i < 8; i++) model_val[i] = '0;
    reset_mid("rst0");

    // Out-of-order completion, in-order retire.
    alloc(5);
    alloc(6);
    alloc(7);
    cdb_drive(2, 32'h33, 1'b0, 0);
    @(negedge clk); commit_none("ooo_pre2"); tick();
    cdb_drive(0, 32'h11, 1'b0, 0);
    @(negedge clk); commit_none("ooo_pre0"); tick();
    cdb_off();
    @(negedge clk); commit_pop("ooo_t0"); tick();
    cdb_drive(1, 32'h22, 1'b0, 0);
    @(negedge clk); commit_none("ooo_pre1"); tick();
    cdb_off();
    @(negedge clk); commit_pop("ooo_t1"); tick();
    @(negedge clk); commit_pop("ooo_t2"); tick();
    @(negedge clk); commit_none("ooo_drained"); tick();

    // Reset with a completed head pending: no commit may escape.
    alloc(1);
    alloc(2);
    cdb_drive(0, 32'h77, 1'b0, 0);
    @(negedge clk); tick();
    cdb_off();
    reset_mid("rst_mid");

    // Fill, refuse a ninth request, retire one, wrap.
    for (int i = 0; i < 8; i++) alloc(5'(i + 1));
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    @(negedge clk);
    check_eq("full_ready", 32'(alloc_ready), 0);
    check_eq("full_tag", 32'(alloc_tag), 32'(exp_tail));
    tick();
    alloc_valid = 1'b0;
    cdb_drive(0, 32'hA0, 1'b0, 0);
    @(negedge clk); check_eq("full_ready2", 32'(alloc_ready), 0); commit_none("full_pre"); tick();
    cdb_off();
    @(negedge clk);
    commit_pop("full_t0");
    check_eq("full_ready_on_retire", 32'(alloc_ready), 0);
    tick();
    @(negedge clk); check_eq("full_ready_after", 32'(alloc_ready), 1); tick();
    alloc(9);
    reset_mid("rst_full");

    // Mispredict flush; allocate and CDB in the flush cycle are dropped.
    alloc(1);
    alloc(2);
    alloc(3);
    alloc(4);
    cdb_drive(0, 32'h44, 1'b1, 32'h60);
    @(negedge clk); commit_none("fl_pre"); tick();
    cdb_drive(1, 32'h55, 1'b0, 0);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    @(negedge clk);
    check_eq("fl_flush", 32'(flush), 1);
    check_eq("fl_pc", flush_pc, 32'h60);
    check_eq("fl_ready", 32'(alloc_ready), 0);
    commit_pop("fl_t0");
    tick();
    alloc_valid = 1'b0;
    cdb_off();
    sb.delete();
    exp_tail = '0;
    rd_tag1  = 3'd1;
    rd_tag2  = 3'd0;
    @(negedge clk);
    check_eq("fl_flush_1cyc", 32'(flush), 0);
    check_eq("fl_pc_clr", flush_pc, 0);
    check_eq("fl_tag0", 32'(alloc_tag), 0);
    check_eq("fl_ready_after", 32'(alloc_ready), 1);
    check_eq("fl_rdy1", 32'(rd_rdy1), 0);
    check_eq("fl_rdy2", 32'(rd_rdy2), 0);
    commit_none("fl_after");
    tick();
    cdb_drive(1, 32'h66, 1'b0, 0);
    @(negedge clk); tick();
    cdb_off();
    @(negedge clk);
    check_eq("fl_late_cdb_rdy", 32'(rd_rdy1), 0);
    commit_none("fl_late_cdb");
    tick();

    // x0 destination retires silently and still advances head.
    alloc(0);
    cdb_drive(0, 32'h99, 1'b0, 0);
    @(negedge clk); tick();
    cdb_off();
    @(negedge clk); commit_pop("x0"); tick();
    @(negedge clk);
    check_eq("x0_head_adv", 32'(commit_tag), 1);
    commit_none("x0_after");
    tick();

    // Lookup: result visible one cycle after the CDB write.
    alloc(3);
    alloc(4);
    alloc(5);
    rd_tag1 = 3'd3;
    rd_tag2 = 3'd2;
    cdb_drive(3, 32'hABCD, 1'b0, 0);
    @(negedge clk);
    check_eq("lk_same_rdy", 32'(rd_rdy1), 0);
    check_eq("lk_same_val", rd_val1, 0);
    tick();
    cdb_off();
    @(negedge clk);
    check_eq("lk_rdy1", 32'(rd_rdy1), 1);
    check_eq("lk_val1", rd_val1, 32'hABCD);
    check_eq("lk_rdy2", 32'(rd_rdy2), 0);
    check_eq("lk_val2", rd_val2, 0);
    commit_none("lk_hold");
    tick();
    cdb_drive(1, 32'h1111, 1'b0, 0);
    @(negedge clk); commit_none("lk_pre1"); tick();
    cdb_drive(2, 32'h2222, 1'b0, 0);
    @(negedge clk); commit_pop("lk_t1"); tick();
    cdb_off();
    @(negedge clk); commit_pop("lk_t2"); tick();
    @(negedge clk); commit_pop("lk_t3"); tick();
    @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 0);
    commit_none("end");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
